// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring-division sequencer for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FLUSH_EN to let flush_i abort an in-flight request.

// state  | meaning
// IDLE   | waiting for a divide request
// START  | operand magnitudes, divide-by-zero / overflow shortcut
// CALC   | one restoring-division step per cycle, XLEN cycles
// END    | result registered, ready_o/reg_we_o high for this cycle
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_we_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] dvd_q, dvs_q, dvs_abs_q, rem_q, quot_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic [CW-1:0]   count;
  logic            accept, init, step, fin, flush;
  logic [XLEN-1:0] result_nxt;

  logic            is_signed, dvd_neg, dvs_neg, dvs_zero, ovf, fits;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] rem_step, quot_step, quot_fix, rem_fix;

`ifdef DIV_FLUSH_EN
  assign flush = flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush        = 1'b0;
`endif

  // funct3[0]=0 selects the signed variants (DIV/REM)
  assign is_signed = ~op_q[0];
  assign dvd_neg   = is_signed & dvd_q[XLEN-1];
  assign dvs_neg   = is_signed & dvs_q[XLEN-1];
  assign dvd_abs   = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_abs   = dvs_neg ? -dvs_q : dvs_q;
  assign dvs_zero  = (dvs_q == '0);
  assign ovf       = is_signed && (dvd_q == MIN_NEG) && (dvs_q == '1);

  // Trial subtract on {rem,quot} shifted left; a positive difference never reaches bit XLEN
  assign shifted   = {rem_q, quot_q[XLEN-1]};
  assign diff      = {1'b0, shifted} - {2'b00, dvs_abs_q};
  assign fits      = ~|diff[XLEN+1:XLEN];
  assign rem_step  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quot_step = {quot_q[XLEN-2:0], fits};
  assign quot_fix  = (dvd_neg ^ dvs_neg) ? -quot_step : quot_step;
  assign rem_fix   = dvd_neg ? -rem_step : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    init       = 1'b0;
    step       = 1'b0;
    fin        = 1'b0;
    result_nxt = '0;
    case (state)
      S_IDLE: begin
        if (start_i && op_i[2]) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (dvs_zero) begin
          fin        = 1'b1;
          result_nxt = op_q[1] ? dvd_q : '1;
          state_nxt  = S_END;
        end else if (ovf) begin
          fin        = 1'b1;
          result_nxt = op_q[1] ? '0 : MIN_NEG;
          state_nxt  = S_END;
        end else begin
          init      = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (count == LAST) begin
          fin        = 1'b1;
          result_nxt = op_q[1] ? rem_fix : quot_fix;
          state_nxt  = S_END;
        end
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      accept    = 1'b0;
      fin       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      dvs_abs_q   <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      count       <= '0;
      result_o    <= '0;
      reg_waddr_o <= '0;
      ready_o     <= 1'b0;
    end else begin
      ready_o <= fin;
      if (accept) begin
        dvd_q <= dividend_i;
        dvs_q <= divisor_i;
        op_q  <= op_i[1:0];
        rd_q  <= reg_waddr_i;
      end
      if (init) begin
        rem_q     <= '0;
        quot_q    <= dvd_abs;
        dvs_abs_q <= dvs_abs;
        count     <= '0;
      end
      if (step) begin
        rem_q  <= rem_step;
        quot_q <= quot_step;
        count  <= count + CW'(1);
      end
      if (fin) begin
        result_o    <= result_nxt;
        reg_waddr_o <= rd_q;
      end
    end
  end

  assign busy_o   = (state != S_IDLE);
  assign reg_we_o = ready_o;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for the RV32M divide/remainder datapath (DIV, DIVU, REM, REMU); decode issues these with register write disabled.
- Accepts one request from the execute stage, runs a 32-step restoring division, and returns the result together with its destination register.
- Execute uses busy_o to hold the pipeline and ready_o to commit the deferred write-back.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN; counter width is clog2(XLEN)+1

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
start_i  input  1  request strobe, sampled only in IDLE
op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
dividend_i  input  XLEN  rs1 value
divisor_i  input  XLEN  rs2 value
reg_waddr_i  input  5  destination rd
flush_i  input  1  pipeline flush (used only with DIV_FLUSH_EN)
result_o  output  XLEN  quotient or remainder, valid while ready_o=1
ready_o  output  1  one-cycle completion pulse
busy_o  output  1  high from the cycle after acceptance until ready_o drops
reg_waddr_o  output  5  latched rd, valid while ready_o=1
reg_we_o  output  1  equals ready_o

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0. result_o=0, ready_o=0, busy_o=0, reg_waddr_o=0, reg_we_o=0. All internal operand registers are cleared.
- States and transitions:
  - IDLE: start_i=1 with a valid op_i[2]=1 latches the operands, op and rd, then goes to START. op_i[2]=0 is ignored. busy_o=0.
  - START: computes the operand magnitudes, using two's-complement absolute value for signed ops (100/110).
    - Divisor==0 -> END with quotient=all-ones and remainder=dividend (raw, unsigned view).
    - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF -> END with quotient=0x80000000 and remainder=0.
    - Otherwise -> CALC with count=0, remainder accumulator=0 and quotient shift register=|dividend|.
  - CALC: each cycle:
    - Shift {rem,quot} left by 1.
    - Trial-subtract |divisor| from the upper XLEN+1 bits.
    - If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
    - count++. After XLEN iterations (count==XLEN-1 this cycle) go to END.
  - END: applies the sign fix (signed ops only, not for the special cases):
    - Quotient is negated if the dividend and divisor signs differ.
    - Remainder is negated if the dividend is negative.
    - result_o selects the quotient for op[1]=0 and the remainder for op[1]=1.
    - ready_o=1 and reg_we_o=1 for exactly this cycle, then return to IDLE.
- Outputs: result_o and reg_waddr_o are registered and hold their value after ready_o drops until the next END.
- Latency (start_i sampled at edge 0):
  - Normal: ready_o is high in cycle 34 (START at 1, CALC at 2..33, END at 34).
  - Special cases: ready_o is high in cycle 2.
  - busy_o is high in cycles 1..34 (normal) or 1..2 (special).
- Boundary conditions:
  - start_i while not IDLE is ignored, with no queueing.
  - start_i in the END cycle is ignored. A new request is accepted the cycle after END.
  - Operand inputs are latched only at acceptance, so later input changes have no effect.
  - XLEN iterations exactly; the counter never wraps inside CALC.
  - Reset mid-operation aborts immediately with no ready_o.

Optional Feature:
- Macro: DIV_FLUSH_EN.
- Defined: flush_i=1 in START/CALC/END forces IDLE on the next edge and suppresses ready_o/reg_we_o for that request. In END, ready_o is still high in that cycle (it is registered), so execute must gate commit with flush.
  - flush_i=1 in IDLE together with start_i drops the request.
  - busy_o falls on the edge after flush.
- Undefined: flush_i is ignored and every accepted request completes.

Test Plan:
- DIVU 100/7, rd=5 -> ready_o in cycle 34, result_o=0x0000000E, reg_waddr_o=5, busy_o high cycles 1..34.
- REM -7 (0xFFFFFFF9) by 2 -> result_o=0xFFFFFFFF. DIV same operands -> 0xFFFFFFFD.
- DIVU 5/0 -> result_o=0xFFFFFFFF in cycle 2. REMU 5/0 -> result_o=5 in cycle 2.
- DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000 in cycle 2. REM same operands -> 0.
- Second start_i in cycle 10 of a running DIVU 100/7 -> ignored: exactly one ready_o pulse, result 0x0E. A new start in cycle 35 is accepted.
- DIV_FLUSH_EN: flush_i in cycle 20 -> no ready_o, busy_o=0 from cycle 21, a new request accepted in cycle 21. Assert rst=0 in cycle 15 -> all outputs 0 asynchronously.
